// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle sequencer for the 16-bit processor: owns PC and IR, fetches over
// a req/ack handshake and steps the datapath through FETCH/DECODE/EXEC/MEM/WB.
module cpu_seq_ctrl (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        alu_zero,
    output logic [3:0]  OPCODE,
    output logic [2:0]  Wreg_Sig,
    output logic [2:0]  Rreg_Sig1,
    output logic [2:0]  Rreg_Sig2,
    output logic [5:0]  Immediate_Addr,
    output logic        Source2_select,
    output logic        ALU_out_Select,
    output logic        RegWrite_Flag,
    output logic        halted,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LD   = 4'h5;
    localparam logic [3:0] OP_ST   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t      state;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic [3:0]  op;
    logic        is_nop;
    logic [7:0]  branch_off;

    assign op         = ir[15:12];
    assign is_nop     = (op >= 4'h9) && (op <= 4'hE);
    assign branch_off = {{2{ir[5]}}, ir[5:0]};

    assign imem_addr      = pc;
    assign OPCODE         = op;
    assign Wreg_Sig       = ir[11:9];
    assign Rreg_Sig1      = ir[8:6];
    assign Rreg_Sig2      = ir[5:3];
    assign Immediate_Addr = ir[5:0];
    assign Source2_select = (op == OP_ADDI) || (op == OP_LD) || (op == OP_ST);
    assign ALU_out_Select = (op == OP_LD);

    // Request/enable outputs are loaded together with the state they belong to,
    // so each one is a flop that follows the next-state decision.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= S_IDLE;
            pc            <= 8'h00;
            ir            <= 16'h0000;
            retired       <= 16'h0000;
            imem_req      <= 1'b0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            RegWrite_Flag <= 1'b0;
            halted        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    pc <= 8'h00;
                    if (start) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        ir       <= imem_rdata;
                        pc       <= pc + 8'h01;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (op == OP_HALT) begin
                        state   <= S_HALT;
                        halted  <= 1'b1;
                        retired <= retired + 16'h0001;
                    end else if (is_nop) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                        retired  <= retired + 16'h0001;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (op == OP_JMP || op == OP_BEQ) begin
                        // pc already points past the branch, so the offset is relative to it
                        if (op == OP_JMP)
                            pc <= ir[7:0];
                        else if (alu_zero)
                            pc <= pc + branch_off;
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                        retired  <= retired + 16'h0001;
                    end else if (op == OP_LD || op == OP_ST) begin
                        state    <= S_MEM;
                        dmem_req <= 1'b1;
                        dmem_we  <= (op == OP_ST);
                    end else begin
                        state         <= S_WB;
                        RegWrite_Flag <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (op == OP_ST) begin
                            state    <= S_FETCH;
                            imem_req <= 1'b1;
                            retired  <= retired + 16'h0001;
                        end else begin
                            state         <= S_WB;
                            RegWrite_Flag <= 1'b1;
                        end
                    end
                end
                S_WB: begin
                    RegWrite_Flag <= 1'b0;
                    imem_req      <= 1'b1;
                    retired       <= retired + 16'h0001;
                    state         <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl: fetch addresses are predicted into a queue
// as instructions are issued and compared when the DUT raises imem_req.
module tb_cpu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack = 1'b0;
    logic        alu_zero = 1'b0;
    logic [3:0]  OPCODE;
    logic [2:0]  Wreg_Sig;
    logic [2:0]  Rreg_Sig1;
    logic [2:0]  Rreg_Sig2;
    logic [5:0]  Immediate_Addr;
    logic        Source2_select;
    logic        ALU_out_Select;
    logic        RegWrite_Flag;
    logic        halted;
    logic [15:0] retired;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_retired = 16'h0000;
    logic [7:0]  exp_addr_q[$];

    cpu_seq_ctrl dut (
        .clk(clk), .rstn(rstn), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .alu_zero(alu_zero),
        .OPCODE(OPCODE), .Wreg_Sig(Wreg_Sig), .Rreg_Sig1(Rreg_Sig1), .Rreg_Sig2(Rreg_Sig2),
        .Immediate_Addr(Immediate_Addr), .Source2_select(Source2_select),
        .ALU_out_Select(ALU_out_Select), .RegWrite_Flag(RegWrite_Flag),
        .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic retire_one(input string tag);
        exp_retired = exp_retired + 16'h0001;
        check(tag, retired, exp_retired);
    endtask

    // Serve one instruction fetch; returns positioned in the DECODE cycle.
    task automatic fetch(input logic [15:0] instr, input int waits);
        logic [7:0] exp;
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        check("fetch_req", imem_req, 16'd1);
        exp = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 8'hxx;
        check("fetch_addr", imem_addr, exp);
        for (int i = 0; i < waits; i++) begin
            step();
            check("fetch_req_hold", imem_req, 16'd1);
            check("fetch_addr_hold", imem_addr, exp);
        end
        imem_ack   = 1'b1;
        imem_rdata = instr;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        check("fetch_req_drop", imem_req, 16'd0);
    endtask

    // Entered in the first MEM cycle; acks after 'waits' extra cycles.
    task automatic mem_access(input int waits, input logic exp_we);
        for (int i = 0; i <= waits; i++) begin
            check("dmem_req_hold", dmem_req, 16'd1);
            check("dmem_we", dmem_we, exp_we);
            if (i == waits) dmem_ack = 1'b1;
            step();
        end
        dmem_ack = 1'b0;
        check("dmem_req_drop", dmem_req, 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        step(); step();
        check("rst_imem_req", imem_req, 16'd0);
        check("rst_imem_addr", imem_addr, 16'd0);
        check("rst_dmem_req", dmem_req, 16'd0);
        check("rst_regwrite", RegWrite_Flag, 16'd0);
        check("rst_halted", halted, 16'd0);
        check("rst_retired", retired, 16'd0);
        check("rst_fields", {OPCODE, Wreg_Sig, Rreg_Sig1, Immediate_Addr}, 16'd0);
        rstn = 1'b1;
        step();
        check("idle_no_req", imem_req, 16'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("first_req", imem_req, 16'd1);

        // ADDI r5,r1,5
        exp_addr_q.push_back(8'h00);
        fetch(16'h4A45, 0);
        check("addi_opcode", OPCODE, 16'h4);
        check("addi_wreg", Wreg_Sig, 16'd5);
        check("addi_rreg1", Rreg_Sig1, 16'd1);
        check("addi_imm", Immediate_Addr, 16'd5);
        check("addi_src2", Source2_select, 16'd1);
        check("addi_wr_decode", RegWrite_Flag, 16'd0);
        step();
        check("addi_wr_exec", RegWrite_Flag, 16'd0);
        step();
        check("addi_wr_wb", RegWrite_Flag, 16'd1);
        step();
        check("addi_wr_after", RegWrite_Flag, 16'd0);
        retire_one("addi_retired");

        // LD r2,r3,4 with 3 dmem wait cycles
        exp_addr_q.push_back(8'h01);
        fetch(16'h54C4, 0);
        check("ld_aluout", ALU_out_Select, 16'd1);
        check("ld_src2", Source2_select, 16'd1);
        step();
        step();
        mem_access(3, 1'b0);
        check("ld_wb", RegWrite_Flag, 16'd1);
        check("ld_aluout_wb", ALU_out_Select, 16'd1);
        step();
        retire_one("ld_retired");

        // ST r5,r0,1 with imem wait and 3 dmem wait cycles
        exp_addr_q.push_back(8'h02);
        fetch(16'h6A01, 2);
        check("st_aluout", ALU_out_Select, 16'd0);
        step();
        step();
        mem_access(3, 1'b1);
        check("st_no_wb", RegWrite_Flag, 16'd0);
        check("st_refetch", imem_req, 16'd1);
        retire_one("st_retired");

        // JMP 0x10, BEQ -4 taken
        exp_addr_q.push_back(8'h03);
        fetch(16'h8010, 0);
        step();
        step();
        retire_one("jmp_retired");
        exp_addr_q.push_back(8'h10);
        fetch(16'h703C, 0);
        step();
        alu_zero = 1'b1;
        step();
        alu_zero = 1'b0;
        retire_one("beq_t_retired");
        exp_addr_q.push_back(8'h0D);

        // JMP back, BEQ -4 not taken
        fetch(16'h8010, 0);
        step();
        step();
        exp_addr_q.push_back(8'h10);
        fetch(16'h703C, 0);
        step();
        alu_zero = 1'b0;
        step();
        exp_retired = exp_retired + 16'h0001;
        retire_one("beq_nt_retired");
        exp_addr_q.push_back(8'h11);

        // BEQ -1 taken: tight loop on itself
        fetch(16'h703F, 0);
        step();
        alu_zero = 1'b1;
        step();
        alu_zero = 1'b0;
        retire_one("beq_loop_retired");
        exp_addr_q.push_back(8'h11);

        // JMP 0xFF then NOP at 0xFF wraps to 0x00
        fetch(16'h80FF, 0);
        step();
        step();
        retire_one("jmpff_retired");
        exp_addr_q.push_back(8'hFF);
        fetch(16'h9000, 0);
        step();
        check("nop_2cyc_req", imem_req, 16'd1);
        retire_one("nop_retired");
        exp_addr_q.push_back(8'h00);

        // HALT is absorbing
        fetch(16'hF000, 0);
        step();
        check("halt_halted", halted, 16'd1);
        retire_one("halt_retired");
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("halt_no_req", imem_req, 16'd0);
        check("halt_stays", halted, 16'd1);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        exp_retired = 16'h0000;
        check("halt_rst_halted", halted, 16'd0);
        check("halt_rst_retired", retired, 16'd0);
        check("halt_rst_opcode", OPCODE, 16'd0);
        check("halt_rst_addr", imem_addr, 16'd0);
        check("halt_rst_req", imem_req, 16'd0);

        // Reset during a long imem wait; late ack must be ignored
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("abort_req", imem_req, 16'd1);
        step();
        step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        check("abort_req_drop", imem_req, 16'd0);
        imem_ack   = 1'b1;
        imem_rdata = 16'h4A45;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        check("late_ack_ir", OPCODE, 16'd0);
        check("late_ack_pc", imem_addr, 16'd0);
        check("late_ack_req", imem_req, 16'd0);

        // Sequencer still works after the abort
        start = 1'b1;
        step();
        start = 1'b0;
        exp_addr_q.push_back(8'h00);
        fetch(16'h4A45, 0);
        check("post_abort_opcode", OPCODE, 16'h4);
        check("post_abort_pc", imem_addr, 16'h01);
        check("queue_empty", exp_addr_q.size(), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
